// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: valid/ready stream carrying drained FIFO words downstream.
interface fifo_rd_stream_if #(
   parameter int G_DATAWIDTH = 32
);
   logic                   m_tvalid;
   logic                   m_tready;
   logic [G_DATAWIDTH-1:0] m_tdata;

   modport master (output m_tvalid, output m_tdata, input m_tready);
   modport slave  (input m_tvalid, input m_tdata, output m_tready);
endinterface

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a non-FWFT FIFO read port into a valid/ready stream through a skid buffer.
// Define FIFO_RD_STREAM_CNT_EN to build the accepted-beat counter; otherwise beat_cnt is tied to zero.
module fifo_rd_stream #(
   parameter int G_DATAWIDTH = 32,
   parameter int G_RDLATENCY = 1
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   flush,
   input  logic                   fifo_empty,
   input  logic [G_DATAWIDTH-1:0] fifo_dout,
   output logic                   fifo_rd_en,
   fifo_rd_stream_if.master       m_axis,
   output logic [31:0]            beat_cnt
);
   localparam int G_DEPTH = G_RDLATENCY + 1;
   localparam int G_CNTW  = $clog2(G_DEPTH + 1);
   localparam int G_PTRW  = $clog2(G_DEPTH);
   localparam logic [G_CNTW:0]   C_DEPTH = (G_CNTW + 1)'(G_DEPTH);
   localparam logic [G_PTRW-1:0] C_LAST  = G_PTRW'(G_DEPTH - 1);

   logic [G_RDLATENCY-1:0] rv_sr;
   logic [G_CNTW-1:0]      inflight;
   logic [G_CNTW-1:0]      buf_cnt;
   logic [G_CNTW-1:0]      buf_cnt_nxt;
   logic [G_CNTW:0]        credit_used;
   logic [G_PTRW-1:0]      head;
   logic [G_PTRW-1:0]      tail;
   logic [G_DATAWIDTH-1:0] mem [G_DEPTH];
   logic                   tvalid_q;
   logic                   pop;
   logic                   ret;

   function automatic logic [G_PTRW-1:0] ptr_inc(input logic [G_PTRW-1:0] p);
      return (p == C_LAST) ? '0 : p + G_PTRW'(1);
   endfunction

   assign pop = tvalid_q & m_axis.m_tready;
   assign ret = rv_sr[G_RDLATENCY-1];

   // Credit covers words already buffered plus words still in the read pipe, so
   // a read is only issued when its return is guaranteed a free slot.
   assign credit_used = {1'b0, buf_cnt} + {1'b0, inflight} - (G_CNTW + 1)'(pop);
   assign fifo_rd_en  = resetn & ~fifo_empty & ~flush & (credit_used < C_DEPTH);
   assign buf_cnt_nxt = buf_cnt + G_CNTW'(ret) - G_CNTW'(pop);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rv_sr    <= '0;
         inflight <= '0;
         buf_cnt  <= '0;
         head     <= '0;
         tail     <= '0;
         tvalid_q <= 1'b0;
      end else if (flush) begin
         rv_sr    <= '0;
         inflight <= '0;
         buf_cnt  <= '0;
         head     <= '0;
         tail     <= '0;
         tvalid_q <= 1'b0;
      end else begin
         rv_sr    <= (rv_sr << 1) | G_RDLATENCY'(fifo_rd_en);
         inflight <= inflight + G_CNTW'(fifo_rd_en) - G_CNTW'(ret);
         buf_cnt  <= buf_cnt_nxt;
         tvalid_q <= (buf_cnt_nxt != '0);
         if (ret) tail <= ptr_inc(tail);
         if (pop) head <= ptr_inc(head);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int unsigned i = 0; i < G_DEPTH; i++) mem[i] <= '0;
      end else if (ret && !flush) begin
         mem[tail] <= fifo_dout;
      end
   end

   assign m_axis.m_tvalid = tvalid_q;
   assign m_axis.m_tdata  = mem[head];

`ifdef FIFO_RD_STREAM_CNT_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)  beat_cnt <= '0;
      else if (pop) beat_cnt <= beat_cnt + 32'd1;
   end
`else
   assign beat_cnt = '0;
`endif
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: runs read latency 1 and 2 side by side on shared stimulus against a queue-level model.
module tb_fifo_rd_stream;
   localparam int DW = 32;
`ifdef FIFO_RD_STREAM_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic flush = 1'b0;
   logic tready = 1'b0;
   logic [1:0] fempty = 2'b11;
   logic [1:0][DW-1:0] fdout = '0;
   logic [1:0] rd_w;
   logic [1:0] tvalid_w;
   logic [1:0][DW-1:0] tdata_w;
   logic [1:0][31:0] beat_w;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [31:0] src [$];
   int          rd_idx [2] = '{0, 0};
   logic [31:0] dp [2][2];
   logic        rd_s [2] = '{1'b0, 1'b0};

   logic [31:0] held   [2][$];
   logic [31:0] infl_d [2][$];
   int          infl_t [2][$];
   int          midx   [2] = '{0, 0};
   logic [31:0] nbeat  [2] = '{32'd0, 32'd0};
   logic [31:0] acc    [2][$];
   int          accc   [2][$];
   int          rdp    [2] = '{0, 0};
   int          fall_c [2] = '{0, 0};
   int          rise_c [2] = '{0, 0};
   logic        prev_e [2] = '{1'b1, 1'b1};
   logic        prev_v [2] = '{1'b0, 1'b0};

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      fifo_rd_stream_if #(.G_DATAWIDTH(DW)) axs ();
      assign axs.m_tready = tready;
      assign tvalid_w[g]  = axs.m_tvalid;
      assign tdata_w[g]   = axs.m_tdata;

      fifo_rd_stream #(.G_DATAWIDTH(DW), .G_RDLATENCY(g + 1)) u_dut (
         .clk        (clk),
         .resetn     (resetn),
         .flush      (flush),
         .fifo_empty (fempty[g]),
         .fifo_dout  (fdout[g]),
         .fifo_rd_en (rd_w[g]),
         .m_axis     (axs.master),
         .beat_cnt   (beat_w[g])
      );
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // FIFO read port: registered dout, G_RDLATENCY stages after the sampled rd_en
   always @(posedge clk) begin
      #2;
      for (int g = 0; g < 2; g++) begin
         dp[g][1] = dp[g][0];
         if (rd_s[g] && rd_idx[g] < src.size()) begin
            dp[g][0] = src[rd_idx[g]];
            rd_idx[g]++;
         end else begin
            dp[g][0] = 32'hDEAD_0000 ^ 32'(cyc);
         end
         fdout[g]  = dp[g][g];
         fempty[g] = (rd_idx[g] >= src.size());
      end
   end

   // Model: held = returned words not yet accepted, infl = words read and still in the pipe
   always @(negedge clk) begin : cmp
      bit ev, pp, er;
      cyc++;
      for (int g = 0; g < 2; g++) begin
         rd_s[g] = rd_w[g];
         if (rd_w[g]) rdp[g]++;
         if (prev_e[g] && !fempty[g]) fall_c[g] = cyc;
         if (!prev_v[g] && tvalid_w[g]) rise_c[g] = cyc;
         prev_e[g] = fempty[g];
         prev_v[g] = tvalid_w[g];
         if (tvalid_w[g] && tready) begin
            acc[g].push_back(tdata_w[g]);
            accc[g].push_back(cyc);
         end
         if (!resetn) begin
            chk("rst_rd_en", rd_w[g], 0);
            chk("rst_tvalid", tvalid_w[g], 0);
            chk("rst_tdata", tdata_w[g], 0);
            chk("rst_beat", beat_w[g], 0);
            held[g].delete();
            infl_d[g].delete();
            infl_t[g].delete();
            nbeat[g] = 0;
         end else begin
            ev = held[g].size() != 0;
            pp = ev && tready;
            er = !fempty[g] && !flush &&
                 (held[g].size() + infl_t[g].size() - int'(pp)) < g + 2;
            chk("rd_en", rd_w[g], er);
            chk("m_tvalid", tvalid_w[g], ev);
            if (ev) chk("m_tdata", tdata_w[g], held[g][0]);
            chk("beat_cnt", beat_w[g], CNT_EN ? nbeat[g] : 32'd0);
            if (pp) nbeat[g] = nbeat[g] + 32'd1;
            if (flush) begin
               held[g].delete();
               infl_d[g].delete();
               infl_t[g].delete();
            end else begin
               if (pp) void'(held[g].pop_front());
               if (infl_t[g].size() != 0 && infl_t[g][0] == cyc) begin
                  held[g].push_back(infl_d[g].pop_front());
                  void'(infl_t[g].pop_front());
               end
            end
            if (er) begin
               infl_d[g].push_back(midx[g] < src.size() ? src[midx[g]] : 32'h0);
               infl_t[g].push_back(cyc + g + 1);
               midx[g]++;
            end
         end
      end
   end

   task automatic check_seq(input string nm, input int g, input int base, input logic [31:0] first, input int n);
      chk({nm, "_cnt"}, acc[g].size() - base, n);
      for (int i = 0; i < n; i++)
         if (acc[g].size() > base + i) chk({nm, "_data"}, acc[g][base + i], first + 32'(i));
   endtask

   initial begin
      int base [2];
      int rb   [2];
      repeat (3) tick();
      @(negedge clk); #1;
      for (int g = 0; g < 2; g++) begin
         chk("reset_outputs", {rd_w[g], tvalid_w[g]}, 0);
         chk("reset_tdata", tdata_w[g], 0);
      end
      tick(); resetn = 1'b1;
      repeat (2) tick();

      // 4 words, ready held high: latency L+1 from empty falling, back-to-back beats
      for (int g = 0; g < 2; g++) base[g] = acc[g].size();
      tready = 1'b1;
      for (int i = 0; i < 4; i++) src.push_back(32'hA0 + 32'(i));
      repeat (12) tick();
      @(negedge clk); #1;
      for (int g = 0; g < 2; g++) begin
         chk("t1_latency", rise_c[g] - fall_c[g], g + 2);
         check_seq("t1", g, base[g], 32'hA0, 4);
         if (accc[g].size() >= base[g] + 4) chk("t1_gapless", accc[g][base[g] + 3] - accc[g][base[g]], 3);
      end

      // Stall with 8 queued: exactly G_DEPTH reads, head word held, then drain with no gaps
      tick(); tready = 1'b0;
      for (int g = 0; g < 2; g++) begin base[g] = acc[g].size(); rb[g] = rdp[g]; end
      for (int i = 0; i < 8; i++) src.push_back(32'hB0 + 32'(i));
      repeat (10) tick();
      @(negedge clk); #1;
      for (int g = 0; g < 2; g++) begin
         chk("t2_rd_pulses", rdp[g] - rb[g], g + 2);
         chk("t2_hold_valid", tvalid_w[g], 1);
         chk("t2_hold_data", tdata_w[g], 32'hB0);
      end
      tick(); tready = 1'b1;
      repeat (16) tick();
      @(negedge clk); #1;
      for (int g = 0; g < 2; g++) begin
         check_seq("t2", g, base[g], 32'hB0, 8);
         if (accc[g].size() >= base[g] + 8) chk("t2_gapless", accc[g][base[g] + 7] - accc[g][base[g]], 7);
      end

      // Toggling ready over 16 words
      for (int g = 0; g < 2; g++) base[g] = acc[g].size();
      tick();
      for (int i = 0; i < 16; i++) src.push_back(32'hC0 + 32'(i));
      for (int i = 0; i < 40; i++) begin tick(); tready = ~tready; end
      tready = 1'b1;
      repeat (10) tick();
      @(negedge clk); #1;
      for (int g = 0; g < 2; g++) check_seq("t3", g, base[g], 32'hC0, 16);

      // Flush the cycle after rd_en: word dropped, next word delivered
      for (int g = 0; g < 2; g++) base[g] = acc[g].size();
      tick(); src.push_back(32'hD0);
      tick(); flush = 1'b1;
      tick(); flush = 1'b0;
      @(negedge clk); #1;
      for (int g = 0; g < 2; g++) chk("t4_flush_tvalid", tvalid_w[g], 0);
      tick(); src.push_back(32'hD1);
      repeat (8) tick();
      @(negedge clk); #1;
      for (int g = 0; g < 2; g++) check_seq("t4", g, base[g], 32'hD1, 1);

      // Flush coinciding with an accepted beat
      tick(); tready = 1'b0;
      src.push_back(32'hE0); src.push_back(32'hE1);
      repeat (6) tick();
      tready = 1'b1; flush = 1'b1;
      tick(); flush = 1'b0;
      @(negedge clk); #1;
      for (int g = 0; g < 2; g++) chk("t4b_tvalid", tvalid_w[g], 0);
      repeat (4) tick();

      // Reset with reads in flight: only post-reset words reach the stream
      for (int g = 0; g < 2; g++) base[g] = acc[g].size();
      for (int i = 0; i < 8; i++) src.push_back(32'hF0 + 32'(i));
      tick();
      tick(); resetn = 1'b0;
      @(negedge clk); #1;
      for (int g = 0; g < 2; g++) begin
         chk("t5_rst_out", {rd_w[g], tvalid_w[g]}, 0);
         chk("t5_rst_data", tdata_w[g], 0);
         chk("t5_rst_beat", beat_w[g], 0);
      end
      tick(); resetn = 1'b1;
      repeat (14) tick();
      @(negedge clk); #1;
      for (int g = 0; g < 2; g++) check_seq("t5", g, base[g], 32'hF2, 6);

      // 14 more beats: 20 accepted since reset
      tick();
      for (int i = 0; i < 14; i++) src.push_back(32'h100 + 32'(i));
      repeat (24) tick();
      @(negedge clk); #1;
      for (int g = 0; g < 2; g++) chk("t6_beat_cnt", beat_w[g], CNT_EN ? 32'd20 : 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
